// File: rtl/spram_ctrl.sv
// Host-side controller for one 16K x 16 single-port RAM macro: request/response channel plus power management.
// Optional deep-sleep state is compiled in with `define SPRAM_SLEEP_EN.
module spram_ctrl #(
  parameter int IDLE_TIMEOUT      = 64,
  parameter int WAKE_CYCLES       = 2,
  parameter int SLEEP_TIMEOUT     = 1024,
  parameter int SLEEP_WAKE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  pwr_state,
  output logic [13:0] ram_address,
  output logic [15:0] ram_datain,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_chipselect,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff,
  input  logic [15:0] ram_dataout
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2,
    ST_SLEEP   = 2'd3
  } state_t;

  localparam bit          IDLE_EN   = (IDLE_TIMEOUT != 0);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);
  localparam logic [15:0] WAKE_LOAD = 16'(WAKE_CYCLES);
`ifdef SPRAM_SLEEP_EN
  localparam logic [15:0] SLEEP_LAST = 16'(SLEEP_TIMEOUT - 1);
  localparam logic [15:0] SLEEP_LOAD = 16'(SLEEP_WAKE_CYCLES);
`endif

  state_t      r_state, w_state_nxt;
  logic [15:0] r_idle_cnt, w_idle_cnt_nxt;
  logic [15:0] r_wake_cnt, w_wake_cnt_nxt;
  logic        r_req_ready;
  logic        r_ram_standby;
  logic        r_rsp_valid;
  logic        w_accept;

  assign w_accept = req_valid & r_req_ready;

  // Next-state logic: idle counting, standby/sleep entry and timed wake-up
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    case (r_state)
      ST_ACTIVE: begin
        // In ACTIVE a present request is always accepted, so it wins over idle expiry
        if (w_accept) begin
          w_idle_cnt_nxt = 16'd0;
        end else if (IDLE_EN && (r_idle_cnt >= IDLE_LAST)) begin
          w_state_nxt    = ST_STANDBY;
          w_idle_cnt_nxt = 16'd0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 16'd1;
        end
      end
      ST_STANDBY: begin
        if (req_valid) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = WAKE_LOAD;
          w_idle_cnt_nxt = 16'd0;
`ifdef SPRAM_SLEEP_EN
        end else if (r_idle_cnt >= SLEEP_LAST) begin
          w_state_nxt    = ST_SLEEP;
          w_idle_cnt_nxt = 16'd0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + 16'd1;
        end
`else
        end else begin
          w_idle_cnt_nxt = r_idle_cnt;
        end
`endif
      end
      ST_WAKE: begin
        if (r_wake_cnt <= 16'd1) begin
          w_state_nxt    = ST_ACTIVE;
          w_wake_cnt_nxt = 16'd0;
          w_idle_cnt_nxt = 16'd0;
        end else begin
          w_wake_cnt_nxt = r_wake_cnt - 16'd1;
        end
      end
      ST_SLEEP: begin
`ifdef SPRAM_SLEEP_EN
        if (req_valid) begin
          w_state_nxt    = ST_WAKE;
          w_wake_cnt_nxt = SLEEP_LOAD;
          w_idle_cnt_nxt = 16'd0;
        end else begin
          w_state_nxt = ST_SLEEP;
        end
`else
        w_state_nxt = ST_ACTIVE;
`endif
      end
      default: begin
        w_state_nxt = ST_ACTIVE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ACTIVE;
      r_idle_cnt    <= 16'd0;
      r_wake_cnt    <= 16'd0;
      r_req_ready   <= 1'b1;
      r_ram_standby <= 1'b0;
      r_rsp_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_wake_cnt    <= w_wake_cnt_nxt;
      r_req_ready   <= (w_state_nxt == ST_ACTIVE);
      r_ram_standby <= (w_state_nxt == ST_STANDBY) || (w_state_nxt == ST_SLEEP);
      r_rsp_valid   <= w_accept & ~req_we;
    end
  end

`ifdef SPRAM_SLEEP_EN
  logic r_ram_sleep;

  // Sleep pin follows the registered SLEEP state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_sleep <= 1'b0;
    end else begin
      r_ram_sleep <= (w_state_nxt == ST_SLEEP);
    end
  end

  assign ram_sleep = r_ram_sleep;
`else
  assign ram_sleep = 1'b0;
`endif

  assign req_ready      = r_req_ready;
  assign pwr_state      = r_state;
  assign ram_standby    = r_ram_standby;
  assign ram_poweroff   = 1'b1;
  // The macro registers its read internally, so DATAOUT lines up with the response cycle
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = ram_dataout;
  assign ram_chipselect = w_accept;
  assign ram_address    = req_addr;
  assign ram_datain     = req_wdata;
  assign ram_wren       = req_we;
  assign ram_maskwren   = {req_be[1], req_be[1], req_be[0], req_be[0]};

endmodule

// File: tb/tb_spram_ctrl.sv
// Scoreboard bench for spram_ctrl: behavioural SPRAM, byte-level reference memory, randomized traffic.
module tb_spram_ctrl;

  localparam int IT  = 4;
  localparam int WC  = 2;
  localparam int ST  = 8;
  localparam int SWC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [13:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  pwr_state;
  logic [13:0] ram_address;
  logic [15:0] ram_datain;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_chipselect, ram_standby, ram_sleep, ram_poweroff;
  logic [15:0] ram_dataout;

  spram_ctrl #(
    .IDLE_TIMEOUT(IT), .WAKE_CYCLES(WC), .SLEEP_TIMEOUT(ST), .SLEEP_WAKE_CYCLES(SWC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pwr_state(pwr_state),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_chipselect(ram_chipselect), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_dataout(ram_dataout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: nibble write masks, registered read port
  logic [15:0] ram_mem [16384];
  logic [15:0] ram_q = 16'h0000;
  assign ram_dataout = ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_wren) begin
        for (int n = 0; n < 4; n++)
          if (ram_maskwren[n]) ram_mem[ram_address][n*4 +: 4] <= ram_datain[n*4 +: 4];
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  // Reference memory kept as separate bytes
  logic [7:0] ref_lo [16384];
  logic [7:0] ref_hi [16384];

  typedef struct { int cyc; logic [15:0] data; } exp_t;
  exp_t sb_q[$];

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding read, in the right cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL rsp_spurious: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_data", {16'h0000, rsp_rdata}, {16'h0000, e.data});
          check("rsp_cycle", cyc, e.cyc);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        ntests++; nfail++;
        $display("FAIL rsp_missing: got rsp_valid=0 expected response in cycle %0d", sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // Issue one request at #1 after a rising edge; returns the number of cycles spent waiting for ready
  task automatic send(input logic we, input logic [13:0] a, input logic [15:0] d,
                      input logic [1:0] be, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      check("cs_gated", {31'd0, ram_chipselect}, 32'd0);
      waits++;
      @(posedge clk); #1;
    end
    if (!ok) begin
      ntests++; nfail++;
      $display("FAIL accept_timeout: got no req_ready expected ready within 60 cycles (addr 0x%0h)", a);
    end else begin
      check("ram_cs", {31'd0, ram_chipselect}, 32'd1);
      check("ram_addr", {18'd0, ram_address}, {18'd0, a});
      check("ram_wren", {31'd0, ram_wren}, {31'd0, we});
      check("ram_maskwren", {28'd0, ram_maskwren}, {28'd0, be[1], be[1], be[0], be[0]});
      if (we) begin
        check("ram_datain", {16'd0, ram_datain}, {16'd0, d});
        if (be[0]) ref_lo[a] = d[7:0];
        if (be[1]) ref_hi[a] = d[15:8];
      end else begin
        exp_t e;
        e.cyc  = cyc + 1;
        e.data = {ref_hi[a], ref_lo[a]};
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwr"}, {30'd0, pwr_state}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_standby"}, {31'd0, ram_standby}, 32'd0);
    check({tag, "_sleep"}, {31'd0, ram_sleep}, 32'd0);
    check({tag, "_poweroff"}, {31'd0, ram_poweroff}, 32'd1);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  int w;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 14'd0; req_wdata = 16'd0; req_be = 2'b00;
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i] = 16'h0000; ref_lo[i] = 8'h00; ref_hi[i] = 8'h00;
    end
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    check("reset_cs", {31'd0, ram_chipselect}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, partial write, back-to-back reads
    send(1'b1, 14'h0005, 16'hBEEF, 2'b11, w);
    send(1'b0, 14'h0005, 16'h0000, 2'b00, w);
    send(1'b1, 14'h3FFF, 16'hBEEF, 2'b11, w);
    send(1'b1, 14'h3FFF, 16'h1234, 2'b01, w);
    send(1'b0, 14'h3FFF, 16'h0000, 2'b00, w);
    send(1'b1, 14'h0001, 16'h1111, 2'b11, w);
    send(1'b1, 14'h0002, 16'h2222, 2'b11, w);
    send(1'b1, 14'h0003, 16'h3333, 2'b11, w);
    send(1'b1, 14'h0003, 16'h9999, 2'b00, w);
    send(1'b0, 14'h0001, 16'h0000, 2'b00, w);
    send(1'b0, 14'h0002, 16'h0000, 2'b00, w);
    send(1'b0, 14'h0003, 16'h0000, 2'b00, w);

    // Idle timeout into STANDBY, then timed wake-up
    repeat (IT - 1) @(posedge clk);
    @(negedge clk);
    check("pre_standby_pwr", {30'd0, pwr_state}, 32'd0);
    @(negedge clk);
    check("standby_pwr", {30'd0, pwr_state}, 32'd1);
    check("standby_pin", {31'd0, ram_standby}, 32'd1);
    check("standby_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0005; req_be = 2'b00;
    for (int k = 0; k <= WC; k++) begin
      @(negedge clk);
      check("wake_ready", {31'd0, req_ready}, 32'd0);
      if (k == 1) begin
        check("wake_pwr", {30'd0, pwr_state}, 32'd2);
        check("wake_standby", {31'd0, ram_standby}, 32'd0);
      end
    end
    send(1'b0, 14'h0005, 16'h0000, 2'b00, w);
    check("wake_latency", w, 32'd0);

    // Request on the idle-expiry cycle wins
    repeat (IT - 1) @(posedge clk); #1;
    send(1'b0, 14'h0002, 16'h0000, 2'b00, w);
    check("expiry_accept", w, 32'd0);
    @(negedge clk);
    check("expiry_no_standby", {30'd0, pwr_state}, 32'd0);

    // Randomized traffic with gaps long enough to hit standby
    for (int i = 0; i < 150; i++) begin
      logic [13:0] a;
      int gap;
      a = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15));
      send(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)), w);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
      if (gap > 0) begin
        repeat (gap) @(posedge clk); #1;
      end
    end

`ifdef SPRAM_SLEEP_EN
    send(1'b1, 14'h0010, 16'hA5A5, 2'b11, w);
    repeat (IT + ST - 1) @(posedge clk);
    @(negedge clk);
    check("pre_sleep", {31'd0, ram_sleep}, 32'd0);
    check("pre_sleep_pwr", {30'd0, pwr_state}, 32'd1);
    @(negedge clk);
    check("sleep_pin", {31'd0, ram_sleep}, 32'd1);
    check("sleep_standby", {31'd0, ram_standby}, 32'd1);
    check("sleep_pwr", {30'd0, pwr_state}, 32'd3);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0010; req_be = 2'b00;
    for (int k = 0; k <= SWC; k++) begin
      @(negedge clk);
      check("swake_ready", {31'd0, req_ready}, 32'd0);
      if (k == 1) begin
        check("swake_pwr", {30'd0, pwr_state}, 32'd2);
        check("swake_sleep", {31'd0, ram_sleep}, 32'd0);
        check("swake_standby", {31'd0, ram_standby}, 32'd0);
      end
    end
    send(1'b0, 14'h0010, 16'h0000, 2'b00, w);
    check("swake_latency", w, 32'd0);
    repeat (IT + ST) @(posedge clk);
    @(negedge clk);
    check("sleep2_pwr", {30'd0, pwr_state}, 32'd3);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("sleep_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    // Reset while a read response is in flight drops it
    send(1'b0, 14'h0001, 16'h0000, 2'b00, w);
    rst_n = 1'b0;
    #1 check_reset_outputs("inflight_rst");
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1'b0, 14'h0003, 16'h0000, 2'b00, w);

    repeat (5) @(posedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
